// File: rtl/egress_fsm_pkg.sv
// Shared definitions for the egress transmit path.
//   axis_source_t : tvalid / tdata[15:0] / tlast driven toward the link
//   axis_sink_t   : tready returned by the link
//   frame_status  : one-hot-ish view of which frame field is being read
//   ETH_SFD, header field word lengths, push-side FSM state encoding,
//   and helpers that map FSM states onto status bits and field lengths.
package egress_fsm_pkg;

    localparam logic [15:0] ETH_SFD = 16'h55D5;

    // Header field lengths in 16-bit words.
    localparam int unsigned DST_MAC_WORDS = 3;
    localparam int unsigned SRC_MAC_WORDS = 3;
    localparam int unsigned TYPE_WORDS    = 1;

    localparam int unsigned FIELD_CNT_W = 2;

    // Push-side FSM state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SFD     = 3'd1;
    localparam logic [2:0] ST_DST_MAC = 3'd2;
    localparam logic [2:0] ST_SRC_MAC = 3'd3;
    localparam logic [2:0] ST_TYPE    = 3'd4;
    localparam logic [2:0] ST_PAYLOAD = 3'd5;
    localparam logic [2:0] ST_DISCARD = 3'd6;
    localparam logic [2:0] ST_GAP     = 3'd7;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic        tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

    typedef struct packed {
        logic scan_frame;
        logic scan_sfd;
        logic scan_dst_mac;
        logic scan_src_mac;
        logic scan_type;
        logic scan_payload;
    } frame_status;

    function automatic frame_status state_status(input logic [2:0] st);
        frame_status s;
        s = '0;
        case (st)
            ST_SFD:     begin s.scan_frame = 1'b1; s.scan_sfd     = 1'b1; end
            ST_DST_MAC: begin s.scan_frame = 1'b1; s.scan_dst_mac = 1'b1; end
            ST_SRC_MAC: begin s.scan_frame = 1'b1; s.scan_src_mac = 1'b1; end
            ST_TYPE:    begin s.scan_frame = 1'b1; s.scan_type    = 1'b1; end
            ST_PAYLOAD: begin s.scan_frame = 1'b1; s.scan_payload = 1'b1; end
            default:    s = '0;
        endcase
        return s;
    endfunction

    // Index of the final word of a header field (field counter terminal value).
    function automatic logic [FIELD_CNT_W-1:0] field_last_idx(input logic [2:0] st);
        logic [FIELD_CNT_W-1:0] idx;
        case (st)
            ST_DST_MAC: idx = FIELD_CNT_W'(DST_MAC_WORDS - 1);
            ST_SRC_MAC: idx = FIELD_CNT_W'(SRC_MAC_WORDS - 1);
            default:    idx = FIELD_CNT_W'(TYPE_WORDS - 1);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered outputs.
//   in_valid/in_ready/in_data   : upstream push side
//   out_valid/out_ready/out_data: downstream AXIS-style side (held while stalled)
//   count                       : number of occupied entries (0..2)
// The output register is the primary entry; the skid register only fills
// when the output is stalled, and always drains into the output first.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             push;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        push         = in_valid && !skid_valid_q;

        if (!out_valid_q || out_ready) begin
            // Output slot frees this cycle: skid entry is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    always_comb begin
        in_ready  = !skid_valid_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        count     = {out_valid_q && skid_valid_q, out_valid_q ^ skid_valid_q};
    end

endmodule

// File: rtl/egress_fsm.sv
// Egress transmit FSM: pops committed frames from the frame buffer and
// streams them as 16-bit AXIS words with tlast on the final word.
//   clk, reset                      : clock, asynchronous active-high reset
//   buf_frame_avail/buf_rd_en       : frame-buffer read request (data next cycle)
//   buf_rd_data/buf_rd_last         : returned word and its end-of-frame flag
//   egress_source/egress_sink       : AXIS toward the link
//   status                          : field currently being read
//   sfd_error/runt_frame            : single-cycle event pulses
//   frames_sent/frames_discarded    : saturating statistics
// Frames whose first word is not ETH_SFD are drained and dropped. After each
// transmitted frame the link sees at least IFG_CYCLES idle cycles.
module egress_fsm
    import egress_fsm_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 buf_frame_avail,
    output logic                 buf_rd_en,
    input  logic [15:0]          buf_rd_data,
    input  logic                 buf_rd_last,
    output axis_source_t         egress_source,
    input  axis_sink_t           egress_sink,
    output frame_status          status,
    output logic                 sfd_error,
    output logic                 runt_frame,
    output logic [CNT_WIDTH-1:0] frames_sent,
    output logic [CNT_WIDTH-1:0] frames_discarded
);

    localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    logic [2:0]             state_q, state_d;
    logic [FIELD_CNT_W-1:0] field_cnt_q, field_cnt_d;
    logic                   rd_pending_q, rd_pending_d;
    logic                   gap_armed_q, gap_armed_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic [CNT_WIDTH-1:0]   disc_q, disc_d;
    logic                   sfd_err_q, sfd_err_d;
    logic                   runt_q, runt_d;

    logic        rd_en;
    logic        credit_ok;
    logic        push_valid;
    logic [16:0] push_data;
    logic        skid_in_ready;
    logic        skid_out_valid;
    logic [16:0] skid_out_data;
    logic [1:0]  skid_count;
    logic        tlast_hs;

    axis_skid_buffer #(
        .WIDTH(17)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (push_valid && skid_in_ready),
        .in_ready (skid_in_ready),
        .in_data  (push_data),
        .out_valid(skid_out_valid),
        .out_ready(egress_sink.tready),
        .out_data (skid_out_data),
        .count    (skid_count)
    );

    always_comb begin
        egress_source.tvalid = skid_out_valid;
        egress_source.tlast  = skid_out_data[16];
        egress_source.tdata  = skid_out_data[15:0];
        tlast_hs = skid_out_valid && skid_out_data[16] && egress_sink.tready;
    end

    // Only one read is ever outstanding: the returned word may be the frame's
    // last, and a second speculative pop would steal from the next frame.
    always_comb begin
        credit_ok = (skid_count + {1'b0, rd_pending_q}) < 2'd2;
        rd_en     = 1'b0;
        if (state_q != ST_GAP) begin
            rd_en = buf_frame_avail && !rd_pending_q && credit_ok;
        end
        rd_pending_d = rd_en;
    end

    // Push-side FSM: every state except IDLE/GAP reacts to a returned word.
    always_comb begin
        state_d     = state_q;
        field_cnt_d = field_cnt_q;
        gap_armed_d = gap_armed_q;
        gap_cnt_d   = gap_cnt_q;
        sfd_err_d   = 1'b0;
        runt_d      = 1'b0;
        push_valid  = 1'b0;
        push_data   = {buf_rd_last, buf_rd_data};

        case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                if (rd_pending_q) begin
                    if (buf_rd_data == ETH_SFD) begin
                        push_valid = 1'b1;
                        if (buf_rd_last) begin
                            runt_d  = 1'b1;
                            state_d = ST_GAP;
                        end else begin
                            field_cnt_d = '0;
                            state_d     = ST_DST_MAC;
                        end
                    end else if (buf_rd_last) begin
                        sfd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DST_MAC, ST_SRC_MAC, ST_TYPE: begin
                if (rd_pending_q) begin
                    push_valid = 1'b1;
                    if (buf_rd_last) begin
                        runt_d  = 1'b1;
                        state_d = ST_GAP;
                    end else if (field_cnt_q == field_last_idx(state_q)) begin
                        field_cnt_d = '0;
                        case (state_q)
                            ST_DST_MAC: state_d = ST_SRC_MAC;
                            ST_SRC_MAC: state_d = ST_TYPE;
                            default:    state_d = ST_PAYLOAD;
                        endcase
                    end else begin
                        field_cnt_d = field_cnt_q + FIELD_CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_pending_q) begin
                    push_valid = 1'b1;
                    if (buf_rd_last) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_DISCARD: begin
                if (rd_pending_q && buf_rd_last) begin
                    sfd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                // Wait for the tlast handshake, then count IFG_CYCLES idle cycles.
                if (!gap_armed_q) begin
                    if (tlast_hs) begin
                        if (IFG_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            gap_armed_d = 1'b1;
                            gap_cnt_d   = '0;
                        end
                    end
                end else if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_GAP && state_q != ST_GAP) begin
            gap_armed_d = 1'b0;
            gap_cnt_d   = '0;
        end
    end

    always_comb begin
        sent_d = sent_q;
        disc_d = disc_q;
        if (tlast_hs && (sent_q != '1)) begin
            sent_d = sent_q + CNT_WIDTH'(1);
        end
        if (sfd_err_d && (disc_q != '1)) begin
            disc_d = disc_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            field_cnt_q  <= '0;
            rd_pending_q <= 1'b0;
            gap_armed_q  <= 1'b0;
            gap_cnt_q    <= '0;
            sent_q       <= '0;
            disc_q       <= '0;
            sfd_err_q    <= 1'b0;
            runt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            field_cnt_q  <= field_cnt_d;
            rd_pending_q <= rd_pending_d;
            gap_armed_q  <= gap_armed_d;
            gap_cnt_q    <= gap_cnt_d;
            sent_q       <= sent_d;
            disc_q       <= disc_d;
            sfd_err_q    <= sfd_err_d;
            runt_q       <= runt_d;
        end
    end

    always_comb begin
        buf_rd_en        = rd_en;
        status           = state_status(state_q);
        sfd_error        = sfd_err_q;
        runt_frame       = runt_q;
        frames_sent      = sent_q;
        frames_discarded = disc_q;
    end

endmodule

// File: tb/tb_egress_fsm.sv
// Self-checking bench for egress_fsm: a queue-based frame buffer feeds the
// DUT, and a frame-level reference predicts the egress word stream, event
// pulses and saturating counters.
module tb_egress_fsm;
    import egress_fsm_pkg::*;

    localparam int unsigned IFG = 4;
    localparam int unsigned CW  = 3;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          buf_frame_avail = 1'b0;
    logic          buf_rd_en;
    logic [15:0]   buf_rd_data = '0;
    logic          buf_rd_last = 1'b0;
    axis_source_t  egress_source;
    axis_sink_t    egress_sink = '0;
    frame_status   status;
    logic          sfd_error, runt_frame;
    logic [CW-1:0] frames_sent, frames_discarded;

    egress_fsm #(
        .IFG_CYCLES(IFG),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .buf_frame_avail (buf_frame_avail),
        .buf_rd_en       (buf_rd_en),
        .buf_rd_data     (buf_rd_data),
        .buf_rd_last     (buf_rd_last),
        .egress_source   (egress_source),
        .egress_sink     (egress_sink),
        .status          (status),
        .sfd_error       (sfd_error),
        .runt_frame      (runt_frame),
        .frames_sent     (frames_sent),
        .frames_discarded(frames_discarded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } word_t;

    word_t buf_q[$];
    word_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int exp_sent = 0, exp_disc = 0, exp_runt = 0;
    int obs_sfd = 0, obs_runt = 0;
    int tready_mode = 0;
    int idle_cnt = 0;
    logic        rd_en_s = 1'b0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = '0;
    logic        after_last = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int n);
        return (n > int'(SAT)) ? 32'(SAT) : 32'(n);
    endfunction

    // One clock: buffer responds after the edge, DUT outputs sampled at negedge.
    task automatic cycle();
        word_t w;
        word_t e;
        @(posedge clk);
        #1;
        if (!reset && rd_en_s && buf_q.size() > 0) begin
            w = buf_q.pop_front();
            buf_rd_data = w.data;
            buf_rd_last = w.last;
        end
        buf_frame_avail = !reset && (buf_q.size() > 0);
        case (tready_mode)
            0:       egress_sink.tready = 1'b1;
            1:       egress_sink.tready = ~egress_sink.tready;
            2:       egress_sink.tready = 1'($urandom_range(0, 1));
            default: egress_sink.tready = 1'b0;
        endcase
        @(negedge clk);
        rd_en_s = buf_rd_en;
        if (rd_en_s) begin
            check_eq("rd_underflow", 32'(buf_q.size() > 0), 1);
        end
        if (prev_stall) begin
            check_eq("hold_while_stalled",
                     32'({egress_source.tvalid, egress_source.tdata, egress_source.tlast}),
                     32'(prev_out));
        end
        prev_stall = egress_source.tvalid && !egress_sink.tready;
        prev_out   = {egress_source.tvalid, egress_source.tdata, egress_source.tlast};
        if (egress_source.tvalid && after_last) begin
            check_eq("ifg_idle_cycles", (idle_cnt >= int'(IFG)) ? 32'(IFG) : 32'(idle_cnt), 32'(IFG));
            after_last = 1'b0;
        end
        if (egress_source.tvalid && egress_sink.tready) begin
            check_eq("word_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("egress_word", 32'({egress_source.tlast, egress_source.tdata}),
                         32'({e.last, e.data}));
            end
            if (egress_source.tlast) begin
                after_last = 1'b1;
                idle_cnt   = 0;
            end
        end else if (!egress_source.tvalid && after_last) begin
            idle_cnt++;
        end
        if (sfd_error)  obs_sfd++;
        if (runt_frame) obs_runt++;
    endtask

    // Queue a frame; the reference decides from the first word whether it goes out.
    task automatic add_frame(input int len, input logic [15:0] first);
        logic [15:0] w;
        bit good;
        good = (first == ETH_SFD);
        for (int i = 0; i < len; i++) begin
            if (i == 0)      w = first;
            else if (i == 7) w = 16'h0800;
            else             w = 16'($urandom);
            buf_q.push_back('{data: w, last: (i == len - 1)});
            if (good) exp_q.push_back('{data: w, last: (i == len - 1)});
        end
        if (good) begin
            exp_sent++;
            if (len <= 8) exp_runt++;
        end else begin
            exp_disc++;
        end
    endtask

    function automatic logic [15:0] bad_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == ETH_SFD) w = w ^ 16'h0001;
        return w;
    endfunction

    task automatic drain(input string tag);
        int b;
        b = 0;
        while ((buf_q.size() > 0 || exp_q.size() > 0) && b < 2000) begin
            cycle();
            b++;
        end
        check_eq({tag, "_drained"}, 32'(buf_q.size() + exp_q.size()), 0);
        repeat (16) cycle();
        check_eq({tag, "_frames_sent"}, 32'(frames_sent), sat(exp_sent));
        check_eq({tag, "_frames_discarded"}, 32'(frames_discarded), sat(exp_disc));
        check_eq({tag, "_runt_pulses"}, 32'(obs_runt), 32'(exp_runt));
        check_eq({tag, "_sfd_error_pulses"}, 32'(obs_sfd), 32'(exp_disc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) cycle();
        check_eq("reset_tvalid", 32'(egress_source.tvalid), 0);
        check_eq("reset_tdata", 32'(egress_source.tdata), 0);
        check_eq("reset_tlast", 32'(egress_source.tlast), 0);
        check_eq("reset_rd_en", 32'(buf_rd_en), 0);
        check_eq("reset_status", 32'(status), 0);
        check_eq("reset_pulses", 32'({sfd_error, runt_frame}), 0);
        check_eq("reset_sent", 32'(frames_sent), 0);
        check_eq("reset_discarded", 32'(frames_discarded), 0);
        reset = 1'b0;
        repeat (2) cycle();

        // 12-word frame, link always ready
        tready_mode = 0;
        add_frame(12, ETH_SFD);
        drain("t1_basic");

        // same shape, tready toggling
        tready_mode = 1;
        add_frame(12, ETH_SFD);
        drain("t2_toggle");

        // bad SFD frame discarded, following good frame intact
        tready_mode = 0;
        add_frame(6, 16'h1234);
        drain("t3_bad_sfd");
        add_frame(12, ETH_SFD);
        drain("t3_after_bad");

        // back-to-back frames observe the inter-frame gap
        add_frame(12, ETH_SFD);
        add_frame(12, ETH_SFD);
        drain("t4_back_to_back");

        // runt: SFD, D0, D1(last)
        add_frame(3, ETH_SFD);
        drain("t5_runt");
        check_eq("t5_idle_status", 32'(status), 0);

        // length boundaries: single word good/bad, header-only, first payload word
        add_frame(1, ETH_SFD);
        drain("b_single_good");
        add_frame(1, bad_word());
        drain("b_single_bad");
        add_frame(8, ETH_SFD);
        drain("b_len8_runt");
        add_frame(9, ETH_SFD);
        drain("b_len9");

        // random traffic with random backpressure; counters saturate
        tready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) add_frame(int'($urandom_range(1, 20)), bad_word());
                else                           add_frame(int'($urandom_range(1, 20)), ETH_SFD);
            end
            drain("rand");
        end
        for (int k = 0; k < 8; k++) add_frame(int'($urandom_range(1, 4)), bad_word());
        drain("disc_saturate");

        // reset in the middle of a payload while the link stalls
        tready_mode = 0;
        add_frame(20, ETH_SFD);
        for (int i = 0; i < 200 && !status.scan_payload; i++) cycle();
        check_eq("t6_reached_payload", 32'(status.scan_payload), 1);
        tready_mode = 3;
        repeat (3) cycle();
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_tvalid_async", 32'(egress_source.tvalid), 0);
        check_eq("t6_sent_async", 32'(frames_sent), 0);
        check_eq("t6_discarded_async", 32'(frames_discarded), 0);
        check_eq("t6_status_async", 32'(status), 0);
        buf_q.delete();
        exp_q.delete();
        exp_sent = 0; exp_disc = 0; exp_runt = 0;
        obs_sfd = 0; obs_runt = 0;
        rd_en_s = 1'b0; prev_stall = 1'b0; after_last = 1'b0; idle_cnt = 0;
        buf_rd_data = '0; buf_rd_last = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        tready_mode = 0;
        add_frame(12, ETH_SFD);
        drain("t6_post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
